// File: rtl/l2_access_ctrl_if.sv
// Request, tag-array, writeback, response and statistics bundle for l2_access_ctrl.
// slave = the controller, master = the requester plus the tag RAM and writeback sink.
interface l2_access_ctrl_if #(
    parameter int WAYS    = 8,
    parameter int TAG_W   = 12,
    parameter int INDEX_W = 14,
    parameter int CNT_W   = 3
);
    localparam int E = 2 + CNT_W + TAG_W;

    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic                 tag_rd_en;
    logic [INDEX_W-1:0]   tag_rd_index;
    logic [WAYS*E-1:0]    tag_rd_data;
    logic                 tag_wr_en;
    logic [INDEX_W-1:0]   tag_wr_index;
    logic [WAYS*E-1:0]    tag_wr_data;
    logic                 wb_valid;
    logic                 wb_ready;
    logic [INDEX_W-1:0]   wb_index;
    logic [TAG_W-1:0]     wb_tag;
    logic                 resp_valid;
    logic                 resp_hit;
    logic [CNT_W-1:0]     resp_way;
    logic [15:0]          stat_hits;
    logic [15:0]          stat_misses;

    modport slave (
        input  req_valid, req_op, req_index, req_tag, tag_rd_data, wb_ready,
        output req_ready, tag_rd_en, tag_rd_index, tag_wr_en, tag_wr_index, tag_wr_data,
               wb_valid, wb_index, wb_tag, resp_valid, resp_hit, resp_way,
               stat_hits, stat_misses
    );

    modport master (
        output req_valid, req_op, req_index, req_tag, tag_rd_data, wb_ready,
        input  req_ready, tag_rd_en, tag_rd_index, tag_wr_en, tag_wr_index, tag_wr_data,
               wb_valid, wb_index, wb_tag, resp_valid, resp_hit, resp_way,
               stat_hits, stat_misses
    );
endinterface

// File: rtl/l2_access_ctrl.sv
// L2 tag-array access controller: set lookup, victim choice, dirty writeback, LRU/tag update.
// Hit/miss counters exist only when L2_STATS_EN is defined; otherwise they read as 0.
module l2_access_ctrl #(
    parameter int WAYS    = 8,
    parameter int TAG_W   = 12,
    parameter int INDEX_W = 14,
    parameter int CNT_W   = 3
) (
    input logic             clk,
    input logic             rst_n,
    l2_access_ctrl_if.slave bus
);
    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [CNT_W-1:0] lru;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, WB, UPDATE} state_t;

    localparam logic [1:0]       OP_WR   = 2'b01;
    localparam logic [1:0]       OP_INV  = 2'b10;
    localparam logic [CNT_W-1:0] LRU_MAX = '1;

    state_t              state;
    logic                ready_q;
    logic [1:0]          op_q;
    logic [INDEX_W-1:0]  idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic                wb_valid_q;
    logic [TAG_W-1:0]    wb_tag_q;
    logic                wr_en_q;
    logic                wr_need_q;
    entry_t [WAYS-1:0]   wr_data_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [CNT_W-1:0]    resp_way_q;

    entry_t [WAYS-1:0]   set_rd;
    entry_t [WAYS-1:0]   new_set;
    logic [WAYS-1:0]     way_vld;
    logic [WAYS-1:0]     way_dirty;
    logic [WAYS-1:0]     way_hit;
    logic                is_inv;
    logic                is_wr;
    logic                hit;
    logic                inv_found;
    logic                need_wb;
    logic                need_wr;
    logic [CNT_W-1:0]    hit_way;
    logic [CNT_W-1:0]    inv_way;
    logic [CNT_W-1:0]    max_way;
    logic [CNT_W-1:0]    max_lru;
    logic [CNT_W-1:0]    vic_way;
    logic [CNT_W-1:0]    acc_way;

    assign set_rd = bus.tag_rd_data;
    assign is_inv = (op_q == OP_INV);
    assign is_wr  = (op_q == OP_WR);

    // Case equality makes an unwritten (X) valid or dirty bit read as 0.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_vld[w]   = (set_rd[w].valid === 1'b1);
        assign way_dirty[w] = (set_rd[w].dirty === 1'b1);
        assign way_hit[w]   = way_vld[w] && (set_rd[w].tag == tag_q);
    end

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        max_way   = '0;
        max_lru   = set_rd[0].lru;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit     = 1'b1;
                hit_way = CNT_W'(w);
            end
            if (!way_vld[w]) begin
                inv_found = 1'b1;
                inv_way   = CNT_W'(w);
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (set_rd[w].lru > max_lru) begin
                max_lru = set_rd[w].lru;
                max_way = CNT_W'(w);
            end
        end
        vic_way = inv_found ? inv_way : max_way;
        acc_way = hit ? hit_way : (is_inv ? '0 : vic_way);
        need_wr = !(is_inv && !hit);
        need_wb = is_inv ? (hit && way_dirty[hit_way])
                         : (!hit && way_vld[vic_way] && way_dirty[vic_way]);
    end

    always_comb begin
        new_set = set_rd;
        if (is_inv) begin
            if (hit) begin
                new_set[hit_way].valid = 1'b0;
                new_set[hit_way].dirty = 1'b0;
            end
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (CNT_W'(w) != acc_way && set_rd[w].lru != LRU_MAX)
                    new_set[w].lru = set_rd[w].lru + 1'b1;
            end
            if (hit) begin
                new_set[acc_way].lru = '0;
                if (is_wr) new_set[acc_way].dirty = 1'b1;
            end else begin
                new_set[acc_way] = '{valid: 1'b1, dirty: is_wr, lru: '0, tag: tag_q};
            end
        end
    end

    // The modified set is captured in LOOKUP so a writeback stall cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            op_q         <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
            wb_valid_q   <= 1'b0;
            wb_tag_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_need_q    <= 1'b0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        op_q    <= bus.req_op;
                        idx_q   <= bus.req_index;
                        tag_q   <= bus.req_tag;
                        state   <= LOOKUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    wr_data_q  <= new_set;
                    wr_need_q  <= need_wr;
                    resp_hit_q <= hit;
                    resp_way_q <= acc_way;
                    wb_tag_q   <= set_rd[acc_way].tag;
                    if (need_wb) begin
                        wb_valid_q <= 1'b1;
                        state      <= WB;
                    end else begin
                        wr_en_q      <= need_wr;
                        resp_valid_q <= 1'b1;
                        state        <= UPDATE;
                    end
                end
                WB: begin
                    if (bus.wb_ready) begin
                        wb_valid_q   <= 1'b0;
                        wr_en_q      <= wr_need_q;
                        resp_valid_q <= 1'b1;
                        state        <= UPDATE;
                    end
                end
                UPDATE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = ready_q;
    assign bus.tag_rd_en    = bus.req_valid && ready_q;
    assign bus.tag_rd_index = bus.req_index;
    assign bus.tag_wr_en    = wr_en_q;
    assign bus.tag_wr_index = idx_q;
    assign bus.tag_wr_data  = wr_data_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_index     = idx_q;
    assign bus.wb_tag       = wb_tag_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_hit     = resp_hit_q;
    assign bus.resp_way     = resp_way_q;

`ifdef L2_STATS_EN
    logic [15:0] hits_q;
    logic [15:0] misses_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state == UPDATE && !is_inv) begin
            if (resp_hit_q) begin
                if (hits_q != 16'hFFFF) hits_q <= hits_q + 16'd1;
            end else if (misses_q != 16'hFFFF) begin
                misses_q <= misses_q + 16'd1;
            end
        end
    end

    assign bus.stat_hits   = hits_q;
    assign bus.stat_misses = misses_q;
`else
    assign bus.stat_hits   = '0;
    assign bus.stat_misses = '0;
`endif
endmodule

// File: tb/tb_l2_access_ctrl.sv
// Directed bench for l2_access_ctrl: tag-RAM model, expected responses queued per request.
module tb_l2_access_ctrl;
    localparam int WAYS    = 8;
    localparam int TAG_W   = 12;
    localparam int INDEX_W = 14;
    localparam int CNT_W   = 3;
    localparam int E       = 2 + CNT_W + TAG_W;
    localparam int SW      = WAYS * E;

    typedef struct {
        logic             hit;
        logic [CNT_W-1:0] way;
        int               lat;
        logic             wb;
        logic [TAG_W-1:0] wbtag;
        int               wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_access_ctrl_if #(.WAYS(WAYS), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) bus ();

    l2_access_ctrl #(.WAYS(WAYS), .TAG_W(TAG_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Tag RAM model: one-cycle read latency, 32 sets addressed by the low index bits.
    logic [SW-1:0] mem [0:31];
    logic          mem_init = 1'b0;
    logic          pl_en = 1'b0;
    logic [4:0]    pl_idx = '0;
    logic [SW-1:0] pl_data = '0;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem_init <= 1'b1;
        end else begin
            if (bus.tag_rd_en) bus.tag_rd_data <= mem[bus.tag_rd_index[4:0]];
            if (bus.tag_wr_en) begin
                mem[bus.tag_wr_index[4:0]] <= bus.tag_wr_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (pl_en) mem[pl_idx] <= pl_data;
        end
    end

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [E-1:0] ent(input logic v, input logic d, input int lru, input int tag);
        return {v, d, CNT_W'(lru), TAG_W'(tag)};
    endfunction

    function automatic logic [E-1:0] way_of(input int idx, input int w);
        logic [SW-1:0] s;
        s = mem[idx];
        return s[w*E +: E];
    endfunction

    task automatic preload(input int idx, input logic [SW-1:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = 5'(idx); pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic send(input string nm, input logic [1:0] op, input int idx, input int tag,
                        input logic eh, input int ew, input int elat, input logic ewb,
                        input int ewbtag, input int stall, input int ewr);
        exp_t e, got;
        int n, wbn, wr0;
        logic wb_seen;
        logic [TAG_W-1:0] wbt;
        logic [INDEX_W-1:0] wbi;
        e = '{hit: eh, way: CNT_W'(ew), lat: elat, wb: ewb, wbtag: TAG_W'(ewbtag), wr: ewr};
        sb.push_back(e);
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        bus.req_valid = 1'b1; bus.req_op = op;
        bus.req_index = INDEX_W'(idx); bus.req_tag = TAG_W'(tag);
        #1;
        check({nm, ".rd_strobe"}, {bus.tag_rd_en, bus.tag_rd_index}, {1'b1, INDEX_W'(idx)});
        wr0 = wr_cnt; wb_seen = 1'b0; wbn = 0; wbt = '0; wbi = '0;
        @(posedge clk); #1;
        n = 1;
        bus.req_valid = 1'b0;
        while (!bus.resp_valid && n < 40) begin
            if (bus.wb_valid) begin
                if (!wb_seen) begin wbt = bus.wb_tag; wbi = bus.wb_index; end
                wb_seen = 1'b1;
                bus.wb_ready = (wbn >= stall);
                wbn++;
            end else begin
                bus.wb_ready = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        bus.wb_ready = 1'b0;
        got = sb.pop_front();
        check({nm, ".resp_valid"}, bus.resp_valid, 1'b1);
        check({nm, ".resp_hit"}, bus.resp_hit, got.hit);
        check({nm, ".resp_way"}, bus.resp_way, got.way);
        check({nm, ".latency"}, n, got.lat);
        check({nm, ".wb_seen"}, wb_seen, got.wb);
        if (got.wb) begin
            check({nm, ".wb_tag"}, wbt, got.wbtag);
            check({nm, ".wb_index"}, wbi, INDEX_W'(idx));
        end
        @(posedge clk); #1;
        check({nm, ".resp_pulse"}, bus.resp_valid, 1'b0);
        check({nm, ".tag_writes"}, wr_cnt - wr0, got.wr);
    endtask

    initial begin
        logic [SW-1:0] s;
        int n, wr0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_index = '0; bus.req_tag = '0;
        bus.wb_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", bus.req_ready, 1'b0);
        check("rst.tag_rd_en", bus.tag_rd_en, 1'b0);
        check("rst.tag_wr_en", bus.tag_wr_en, 1'b0);
        check("rst.wb_valid", bus.wb_valid, 1'b0);
        check("rst.resp_valid", bus.resp_valid, 1'b0);
        check("rst.resp_hit", bus.resp_hit, 1'b0);
        check("rst.resp_way", bus.resp_way, '0);
        check("rst.stat_hits", bus.stat_hits, 16'h0);
        check("rst.stat_misses", bus.stat_misses, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.ready_after", bus.req_ready, 1'b1);

        send("rd_miss", 2'b00, 5, 'h1A, 1'b0, 0, 2, 1'b0, 0, 0, 1);
        check("rd_miss.way0", way_of(5, 0), ent(1, 0, 0, 'h1A));
        check("rd_miss.way3", way_of(5, 3), ent(0, 0, 1, 0));

        send("rd_hit", 2'b00, 5, 'h1A, 1'b1, 0, 2, 1'b0, 0, 0, 1);
        check("rd_hit.way0", way_of(5, 0), ent(1, 0, 0, 'h1A));
        check("rd_hit.way3", way_of(5, 3), ent(0, 0, 2, 0));

        for (int w = 0; w < WAYS; w++)
            s[w*E +: E] = ent(1, w == 7, w, (w == 7) ? 'h3F : 'h100 + w);
        preload(9, s);
        send("wr_miss_wb", 2'b01, 9, 'h44, 1'b0, 7, 6, 1'b1, 'h3F, 3, 1);
        check("wr_miss_wb.way7", way_of(9, 7), ent(1, 1, 0, 'h44));
        check("wr_miss_wb.way6", way_of(9, 6), ent(1, 0, 7, 'h106));
        check("wr_miss_wb.way0", way_of(9, 0), ent(1, 0, 1, 'h100));

        send("wr_hit", 2'b01, 9, 'h44, 1'b1, 7, 2, 1'b0, 0, 0, 1);
        check("wr_hit.way7", way_of(9, 7), ent(1, 1, 0, 'h44));
        check("wr_hit.way6_sat", way_of(9, 6), ent(1, 0, 7, 'h106));
        check("wr_hit.way5", way_of(9, 5), ent(1, 0, 7, 'h105));

        send("inv_dirty", 2'b10, 9, 'h44, 1'b1, 7, 3, 1'b1, 'h44, 0, 1);
        check("inv_dirty.way7", way_of(9, 7), ent(0, 0, 0, 'h44));
        check("inv_dirty.way0_lru", way_of(9, 0), ent(1, 0, 2, 'h100));

        send("inv_miss", 2'b10, 9, 'h55, 1'b0, 0, 2, 1'b0, 0, 0, 0);

        send("fill_inv_way", 2'b00, 9, 'h77, 1'b0, 7, 2, 1'b0, 0, 0, 1);
        check("fill_inv_way.way7", way_of(9, 7), ent(1, 0, 0, 'h77));
        check("fill_inv_way.way0", way_of(9, 0), ent(1, 0, 3, 'h100));

        for (int w = 0; w < WAYS; w++)
            s[w*E +: E] = ent(1, 0, 1, (w == 2 || w == 5) ? 'hAB : 'h200 + w);
        preload(12, s);
        send("lowest_hit", 2'b00, 12, 'hAB, 1'b1, 2, 2, 1'b0, 0, 0, 1);
        check("lowest_hit.way2", way_of(12, 2), ent(1, 0, 0, 'hAB));
        check("lowest_hit.way5", way_of(12, 5), ent(1, 0, 2, 'hAB));

        for (int w = 0; w < WAYS; w++) s[w*E +: E] = ent(1, 0, 0, 'h300 + w);
        s[0 +: E] = {E{1'bx}};
        preload(13, s);
        send("x_valid", 2'b00, 13, 'hCD, 1'b0, 0, 2, 1'b0, 0, 0, 1);
        check("x_valid.way0", way_of(13, 0), ent(1, 0, 0, 'hCD));
        check("x_valid.way1", way_of(13, 1), ent(1, 0, 1, 'h301));

        send("op11_read", 2'b11, 5, 'h1A, 1'b1, 0, 2, 1'b0, 0, 0, 1);
        check("op11_read.way0", way_of(5, 0), ent(1, 0, 0, 'h1A));

        for (int w = 0; w < WAYS; w++) s[w*E +: E] = ent(1, 0, (w == 1 || w == 4) ? 5 : 2, 'h400 + w);
        preload(14, s);
        send("lru_tie", 2'b01, 14, 'h99, 1'b0, 1, 2, 1'b0, 0, 0, 1);
        check("lru_tie.way1", way_of(14, 1), ent(1, 1, 0, 'h99));
        check("lru_tie.way4", way_of(14, 4), ent(1, 0, 6, 'h404));

`ifdef L2_STATS_EN
        check("stats.hits", bus.stat_hits, 16'd4);
        check("stats.misses", bus.stat_misses, 16'd5);
`else
        check("stats.hits", bus.stat_hits, 16'd0);
        check("stats.misses", bus.stat_misses, 16'd0);
`endif

        for (int w = 0; w < WAYS; w++) s[w*E +: E] = ent(1, 1, w, 'h500 + w);
        preload(20, s);
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_index = INDEX_W'(20); bus.req_tag = TAG_W'('h5);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.wb_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("rst_wb.reached", bus.wb_valid, 1'b1);
        wr0 = wr_cnt;
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("rst_wb.wb_valid", bus.wb_valid, 1'b0);
        check("rst_wb.tag_wr_en", bus.tag_wr_en, 1'b0);
        check("rst_wb.resp_valid", bus.resp_valid, 1'b0);
        check("rst_wb.req_ready", bus.req_ready, 1'b0);
        check("rst_wb.stat_hits", bus.stat_hits, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb.no_write", wr_cnt - wr0, 0);
        check("rst_wb.way7_kept", way_of(20, 7), ent(1, 1, 7, 'h507));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_wb.ready_after", bus.req_ready, 1'b1);

        send("post_rst_hit", 2'b00, 20, 'h507, 1'b1, 7, 2, 1'b0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
